// File: rtl/axi_info_regbank.sv
`default_nettype none
// ==========================================================================
// axi_info_regbank: AXI4-Lite slave, build-time RO info words + RW scratch/irq
// Revision: 1.0
// ==========================================================================
module axi_info_regbank #(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int REG_DATA_WIDTH     = 64,
  parameter int REGNUM_RO          = 8,
  parameter int REGNUM_RW          = 4,
  parameter logic [REG_DATA_WIDTH*REGNUM_RO-1:0] INIT    = '0,
  parameter logic [REG_DATA_WIDTH*REGNUM_RW-1:0] RW_INIT = '0,
  parameter int IRQ_EN             = 1
) (
  input  logic                            S_AXI_ACLK_i,
  input  logic                            S_AXI_ARESET_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR_i,
  input  logic                            S_AXI_AWVALID_i,
  output logic                            S_AXI_AWREADY_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA_i,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB_i,
  input  logic                            S_AXI_WVALID_i,
  output logic                            S_AXI_WREADY_o,
  output logic [1:0]                      S_AXI_BRESP_o,
  output logic                            S_AXI_BVALID_o,
  input  logic                            S_AXI_BREADY_i,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR_i,
  input  logic                            S_AXI_ARVALID_i,
  output logic                            S_AXI_ARREADY_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA_o,
  output logic [1:0]                      S_AXI_RRESP_o,
  output logic                            S_AXI_RVALID_o,
  input  logic                            S_AXI_RREADY_i,
  output logic                            INTERRUPT_o
);

  localparam int unsigned BYTES    = REG_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned ALIGN    = C_S_AXI_DATA_WIDTH / REG_DATA_WIDTH;
  localparam int unsigned LANE_W   = (ALIGN > 1) ? $clog2(ALIGN) : 1;
  localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned NRO      = REGNUM_RO;
  localparam int unsigned NRW      = REGNUM_RW;
  localparam int unsigned NREG     = NRO + NRW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t                         wstate_q;
  rstate_t                         rstate_q;
  logic                            awready_q, wready_q, bvalid_q;
  logic                            aw_held_q, w_held_q;
  logic [1:0]                      bresp_q, rresp_q;
  logic [IDX_W-1:0]                awidx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                            arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [REG_DATA_WIDTH-1:0]       rw_q [REGNUM_RW];

  logic [IDX_W-1:0]                w_aw_idx, w_ar_idx;
  int unsigned                     w_aw_lane, w_ar_lane;
  logic [REG_DATA_WIDTH-1:0]       w_data_lane, w_rd_word;
  logic [BYTES-1:0]                w_strb_lane;
  logic                            w_wr_rw;
  logic [1:0]                      w_bresp, w_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_data;
  logic                            w_unused_lsbs;

  assign w_unused_lsbs = ^{S_AXI_AWADDR_i[ADDR_LSB-1:0], S_AXI_ARADDR_i[ADDR_LSB-1:0]};

  // Write decode works on the captured address/data so AW and W can arrive apart.
  always_comb begin
    w_aw_idx    = awidx_q;
    w_aw_lane   = (ALIGN > 1) ? 32'(w_aw_idx[LANE_W-1:0]) : 32'd0;
    w_data_lane = '0;
    w_strb_lane = '0;
    for (int unsigned l = 0; l < ALIGN; l++) begin
      if (w_aw_lane == l) begin
        w_data_lane = wdata_q[l*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        w_strb_lane = wstrb_q[l*BYTES +: BYTES];
      end
    end
    w_wr_rw = 1'b0;
    w_bresp = RESP_DECERR;
    if (32'(w_aw_idx) < NRO) begin
      w_bresp = RESP_SLVERR;
    end else if (32'(w_aw_idx) < NREG) begin
      w_bresp = RESP_OKAY;
      w_wr_rw = 1'b1;
    end
  end

  always_comb begin
    w_ar_idx  = S_AXI_ARADDR_i[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    w_ar_lane = (ALIGN > 1) ? 32'(w_ar_idx[LANE_W-1:0]) : 32'd0;
    w_rd_word = '0;
    w_rresp   = RESP_DECERR;
    for (int unsigned r = 0; r < NRO; r++) begin
      if (32'(w_ar_idx) == r) begin
        w_rd_word = INIT[r*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        w_rresp   = RESP_OKAY;
      end
    end
    for (int unsigned r = 0; r < NRW; r++) begin
      if (32'(w_ar_idx) == NRO + r) begin
        w_rd_word = rw_q[r];
        w_rresp   = RESP_OKAY;
      end
    end
    w_rd_data = '0;
    for (int unsigned l = 0; l < ALIGN; l++) begin
      if (w_ar_lane == l) begin
        w_rd_data[l*REG_DATA_WIDTH +: REG_DATA_WIDTH] = w_rd_word;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK_i) begin
    if (S_AXI_ARESET_i) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int unsigned r = 0; r < NRW; r++) begin
        rw_q[r] <= RW_INIT[r*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (!aw_held_q) begin
            if (S_AXI_AWVALID_i && awready_q) begin
              awidx_q   <= S_AXI_AWADDR_i[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
              aw_held_q <= 1'b1;
              awready_q <= 1'b0;
            end else begin
              awready_q <= 1'b1;
            end
          end
          if (!w_held_q) begin
            if (S_AXI_WVALID_i && wready_q) begin
              wdata_q  <= S_AXI_WDATA_i;
              wstrb_q  <= S_AXI_WSTRB_i;
              w_held_q <= 1'b1;
              wready_q <= 1'b0;
            end else begin
              wready_q <= 1'b1;
            end
          end
          if (aw_held_q && w_held_q) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_bresp;
            wstate_q  <= W_RESP;
            for (int unsigned r = 0; r < NRW; r++) begin
              if (w_wr_rw && (32'(w_aw_idx) == NRO + r)) begin
                for (int unsigned j = 0; j < BYTES; j++) begin
                  if (w_strb_lane[j]) rw_q[r][j*8 +: 8] <= w_data_lane[j*8 +: 8];
                end
              end
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK_i) begin
    if (S_AXI_ARESET_i) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (S_AXI_ARVALID_i && arready_q) begin
            rdata_q   <= w_rd_data;
            rresp_q   <= w_rresp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY_i) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY_o = awready_q;
  assign S_AXI_WREADY_o  = wready_q;
  assign S_AXI_BVALID_o  = bvalid_q;
  assign S_AXI_BRESP_o   = bresp_q;
  assign S_AXI_ARREADY_o = arready_q;
  assign S_AXI_RVALID_o  = rvalid_q;
  assign S_AXI_RDATA_o   = rdata_q;
  assign S_AXI_RRESP_o   = rresp_q;
  assign INTERRUPT_o     = (IRQ_EN != 0) ? rw_q[0][0] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_axi_info_regbank.sv
`default_nettype none
// ==========================================================================
// tb_axi_info_regbank: directed vector bench for axi_info_regbank
// Revision: 1.0
// ==========================================================================
module tb_axi_info_regbank;

  localparam logic [511:0] C_INIT = {64'h0, 64'h0, 64'h0, 64'h0,
                                     64'hDEAD_BEEF_0123_4567, 64'h0,
                                     64'hAAAA_5555_0000_1111, 64'h0123_4567_89AB_CDEF};
  localparam logic [255:0] C_RW_INIT = {64'h0, 64'h0000_0000_0000_CAFE, 64'h0, 64'h0};
  localparam logic [63:0]  C_INIT0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0]  C_FF    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk, rst;
  logic [11:0]  awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, irq;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic [1:0]   bresp, rresp;

  int total = 0;
  int bad   = 0;

  axi_info_regbank #(
    .INIT    (C_INIT),
    .RW_INIT (C_RW_INIT)
  ) dut (
    .S_AXI_ACLK_i    (clk),
    .S_AXI_ARESET_i  (rst),
    .S_AXI_AWADDR_i  (awaddr),
    .S_AXI_AWVALID_i (awvalid),
    .S_AXI_AWREADY_o (awready),
    .S_AXI_WDATA_i   (wdata),
    .S_AXI_WSTRB_i   (wstrb),
    .S_AXI_WVALID_i  (wvalid),
    .S_AXI_WREADY_o  (wready),
    .S_AXI_BRESP_o   (bresp),
    .S_AXI_BVALID_o  (bvalid),
    .S_AXI_BREADY_i  (bready),
    .S_AXI_ARADDR_i  (araddr),
    .S_AXI_ARVALID_i (arvalid),
    .S_AXI_ARREADY_o (arready),
    .S_AXI_RDATA_o   (rdata),
    .S_AXI_RRESP_o   (rresp),
    .S_AXI_RVALID_o  (rvalid),
    .S_AXI_RREADY_i  (rready),
    .INTERRUPT_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout", name);
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_read(input logic [11:0] addr, output logic [127:0] data,
                         output logic [1:0] resp);
    int n = 0;
    araddr  = addr;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("ar_wait");
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    chk1("rvalid_latency1", rvalid, 1'b1);
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [127:0] data,
                          input logic [15:0] strb, input int wlead, input int bhold,
                          output logic [1:0] resp);
    int n = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic [1:0] first_resp;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_done && w_done) && n < 20) begin
      wvalid  = !w_done;
      awvalid = !aw_done && (n >= wlead);
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      if (w_done && !aw_done) begin
        chk1("wready_drop", wready, 1'b0);
        chk1("awready_hold", awready, 1'b1);
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (n >= 20) timeout("aw_w_wait");
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("b_wait");
    first_resp = bresp;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk1("bp_bvalid", bvalid, 1'b1);
      chk("bp_bresp", 128'(bresp), 128'(first_resp));
      chk1("bp_awready", awready, 1'b0);
      chk1("bp_wready", wready, 1'b0);
    end
    resp   = bresp;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  typedef struct {
    bit           wr;
    logic [11:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    int           wlead;
    logic [1:0]   resp;
    logic [127:0] rdata;
    logic         irq;
  } vec_t;

  vec_t         v[16];
  logic [127:0] d;
  logic [1:0]   r;

  initial begin
    rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 0; rready = 0; wdata = '0; wstrb = '0;

    v[0]  = '{0, 12'h018, 128'h0, 16'h0, 0, 2'b00, {64'hDEAD_BEEF_0123_4567, 64'h0}, 1'b0};
    v[1]  = '{0, 12'h000, 128'h0, 16'h0, 0, 2'b00, {64'h0, C_INIT0}, 1'b0};
    v[2]  = '{1, 12'h040, 128'h1, 16'h00FF, 3, 2'b00, 128'h0, 1'b1};
    v[3]  = '{0, 12'h040, 128'h0, 16'h0, 0, 2'b00, 128'h1, 1'b1};
    v[4]  = '{1, 12'h048, {C_FF, C_FF}, 16'h0300, 0, 2'b00, 128'h0, 1'b1};
    v[5]  = '{0, 12'h048, 128'h0, 16'h0, 0, 2'b00, {64'hFFFF, 64'h0}, 1'b1};
    v[6]  = '{1, 12'h000, {C_FF, C_FF}, 16'hFFFF, 0, 2'b10, 128'h0, 1'b1};
    v[7]  = '{0, 12'h000, 128'h0, 16'h0, 0, 2'b00, {64'h0, C_INIT0}, 1'b1};
    v[8]  = '{0, 12'h060, 128'h0, 16'h0, 0, 2'b11, 128'h0, 1'b1};
    v[9]  = '{1, 12'h060, {C_FF, C_FF}, 16'hFFFF, 0, 2'b11, 128'h0, 1'b1};
    v[10] = '{0, 12'h050, 128'h0, 16'h0, 0, 2'b00, {64'h0, 64'hCAFE}, 1'b1};
    v[11] = '{1, 12'h058, {64'h1122_3344_5566_7788, C_FF}, 16'hFFFF, 1, 2'b00, 128'h0, 1'b1};
    v[12] = '{0, 12'h058, 128'h0, 16'h0, 0, 2'b00, {64'h1122_3344_5566_7788, 64'h0}, 1'b1};
    v[13] = '{1, 12'h040, {C_FF, C_FF}, 16'hFF00, 0, 2'b00, 128'h0, 1'b1};
    v[14] = '{1, 12'h040, 128'h0, 16'h0001, 0, 2'b00, 128'h0, 1'b0};
    v[15] = '{0, 12'h008, 128'h0, 16'h0, 0, 2'b00, {64'hAAAA_5555_0000_1111, 64'h0}, 1'b0};

    repeat (3) @(negedge clk);
    chk1("rst_awready", awready, 1'b0);
    chk1("rst_wready", wready, 1'b0);
    chk1("rst_arready", arready, 1'b0);
    chk1("rst_bvalid", bvalid, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 128'h0);
    chk("rst_resps", 128'({bresp, rresp}), 128'h0);
    chk1("rst_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_readies", awready & wready & arready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      if (v[i].wr) begin
        do_write(v[i].addr, v[i].wdata, v[i].wstrb, v[i].wlead, 0, r);
        chk($sformatf("vec%0d_bresp", i), 128'(r), 128'(v[i].resp));
      end else begin
        do_read(v[i].addr, d, r);
        chk($sformatf("vec%0d_rresp", i), 128'(r), 128'(v[i].resp));
        chk($sformatf("vec%0d_rdata", i), d, v[i].rdata);
      end
      chk1($sformatf("vec%0d_irq", i), irq, v[i].irq);
    end

    // Read backpressure: response must hold while RREADY stays low.
    araddr = 12'h018; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("rbp_rvalid", rvalid, 1'b1);
      chk("rbp_rdata", rdata, {64'hDEAD_BEEF_0123_4567, 64'h0});
      chk("rbp_rresp", 128'(rresp), 128'h0);
      chk1("rbp_arready", arready, 1'b0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    chk1("rbp_rvalid_clr", rvalid, 1'b0);
    chk1("rbp_arready_back", arready, 1'b1);

    // Write backpressure with an all-zero strobe leaves RW2 untouched.
    do_write(12'h050, {C_FF, C_FF}, 16'h0000, 0, 5, r);
    chk("wbp_bresp", 128'(r), 128'h0);
    do_read(12'h050, d, r);
    chk("wbp_rw2", d, {64'h0, 64'hCAFE});

    // Read and write to RW1 hand-shake together; read sees the old value.
    awaddr = 12'h048; araddr = 12'h048;
    wdata = {64'h1234_5678_9ABC_DEF0, 64'h0}; wstrb = 16'hFF00;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk1("same_rvalid", rvalid, 1'b1);
    chk("same_rdata_old", rdata, {64'hFFFF, 64'h0});
    rready = 1; bready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
    chk1("same_bvalid", bvalid, 1'b1);
    chk("same_bresp", 128'(bresp), 128'h0);
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    do_read(12'h048, d, r);
    chk("same_rdata_new", d, {64'h1234_5678_9ABC_DEF0, 64'h0});

    // Reset while BVALID is pending after RW0=5.
    awaddr = 12'h040; wdata = 128'h5; wstrb = 16'h00FF;
    awvalid = 1; wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(posedge clk);
    @(negedge clk);
    chk1("rstb_bvalid_before", bvalid, 1'b1);
    chk1("rstb_irq_before", irq, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("rstb_bvalid", bvalid, 1'b0);
    chk1("rstb_irq", irq, 1'b0);
    chk1("rstb_awready", awready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("rstb_readies", awready & wready & arready, 1'b1);
    do_read(12'h040, d, r);
    chk("rstb_rw0", d, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
